sram_controller: RTL
====================

# sram_controller

Responder side of the MEM-stage data-memory interface: accepts the single-word read/write request the MEM stage issues and services it from an external 16-bit asynchronous SRAM. Each 32-bit word takes two 16-bit half-word accesses. `ready` stays low while an access is in flight; the pipeline freezes on it. The block sits between the MEM stage and the board SRAM pins and replaces the single-cycle data memory.

## Interface
- `BASE_ADDR`, 1024 — byte address of data word 0; subtracted before mapping.
- `ACCESS_CYCLES`, 2 — clock cycles per 16-bit SRAM access (≥1).
- `clk`  in  1  — system clock, single clock domain.
- `rst`  in  1  — asynchronous, active-high reset.
- `wr_en`  in  1  — write request from MEM stage, held until `ready`.
- `rd_en`  in  1  — read request from MEM stage, held until `ready`.
- `address`  in  32  — byte address (ALU result).
- `write_data`  in  32  — store data (reg2 value).
- `read_data`  out  32  — loaded word, registered.
- `ready`  out  1  — high: no access pending / access completes this cycle; low: freeze pipeline.
- `SRAM_ADDR`  out  18  — half-word address to SRAM.
- `SRAM_DQ`  inout  16  — SRAM data bus.
- `SRAM_WE_N`  out  1  — SRAM write enable, active low.

## Operation
- Word index `w = (address - BASE_ADDR) >> 2`, 32-bit subtraction, wrap ignored. Half-word addresses: low half `{w[16:0],1'b0}`, high half `{w[16:0],1'b1}`.
- FSM states: IDLE, LOW, HIGH, DONE. A cycle counter `cnt` runs 0..ACCESS_CYCLES-1 inside LOW and HIGH.
- IDLE → LOW: when `rd_en | wr_en`. Request type and address are latched at this edge; later input changes are ignored until DONE.
- LOW: drives the low-half address. Moves to HIGH after ACCESS_CYCLES cycles.
- HIGH: drives the high-half address. Moves to DONE after ACCESS_CYCLES cycles.
- DONE: asserts `ready`, then always returns to IDLE.
- `ready = (state==IDLE & !rd_en & !wr_en) | state==DONE`. This output is combinational.
- Read: on the last LOW cycle, `read_data[15:0] <= SRAM_DQ`. On the last HIGH cycle, `read_data[31:16] <= SRAM_DQ`. `read_data` holds its value until the next read overwrites it.
- Write: `SRAM_WE_N = 0` during every LOW/HIGH cycle. `SRAM_DQ` carries `write_data[15:0]` in LOW and `write_data[31:16]` in HIGH; it is high-Z otherwise. `read_data` is unchanged by a write.
- `rd_en & wr_en` together is an illegal request; the block treats it as a write.
- A request dropped mid-access does not abort it; the access completes and `ready` pulses in DONE.
- If the request is still (or newly) asserted in the IDLE cycle after DONE, a new access starts there. Back-to-back accesses therefore cost 2·ACCESS_CYCLES+2 cycles each.

## Timing
- Reset values (asynchronous, immediate):
  - state = IDLE, `cnt` = 0, `read_data` = 0.
  - `SRAM_ADDR` = 0, `SRAM_WE_N` = 1, `SRAM_DQ` = Z.
  - `ready` = 1 when no request is present.
- Latency: request first seen in IDLE at cycle 0 → `ready` high in cycle 2·ACCESS_CYCLES+1 (cycle 5 by default). The pipeline advances at the end of that cycle.
- Read data is valid on `read_data` during the DONE cycle, one cycle before the MEM/WB register samples it.
- Reset mid-access: the FSM returns to IDLE at once and `SRAM_WE_N` releases to 1. A partial write may leave SRAM half-updated; this is accepted. A partial read leaves `read_data` = 0.
- There is no request queue; the pipeline freeze guarantees at most one outstanding access.

## Structure
- Shared package holds:
  - state encoding (IDLE/LOW/HIGH/DONE, 2 bits);
  - `SRAM_ADDR_W` = 18, `SRAM_DATA_W` = 16;
  - default `BASE_ADDR`.
- RTL is a single module with no sub-module.
- The testbench uses a separate behavioral `sram_model`: a 2^18 × 16 array with write on `SRAM_WE_N` low, driving `SRAM_DQ` when `SRAM_WE_N` is high.

## Test plan
- Idle, no request → `ready` = 1, `SRAM_WE_N` = 1, `SRAM_DQ` = Z for 10 cycles.
- Write `address` = 1024, `write_data` = 0xDEADBEEF:
  - `ready` low for cycles 0–4, high in cycle 5;
  - model holds [0] = 0xBEEF and [1] = 0xDEAD.
- Read `address` = 1024 after that write → `read_data` = 0xDEADBEEF in cycle 5. Read of 1028 with the model preset to [2] = 0x5678, [3] = 0x1234 → 0x12345678.
- Back-to-back: write 1032 = 0x0000CAFE, then read 1032 → `ready` pulses at cycles 5 and 11; `read_data` = 0x0000CAFE.
- Reset asserted in cycle 2 of a write → `ready` returns to 1 immediately, `SRAM_WE_N` = 1. A following read completes normally after 5 cycles.
- Run with ACCESS_CYCLES = 1, `rd_en` & `wr_en` both high → the access is treated as a write, with `ready` in cycle 3.

Source files
------------

// File: rtl/sram_controller_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller.
// Holds the FSM encoding, SRAM bus widths and the default data-segment base.
package sram_controller_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOW  = 2'd1,
      ST_HIGH = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   localparam int SRAM_ADDR_W = 18;
   localparam int SRAM_DATA_W = 16;

   localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

   // Word index of a byte address inside the data segment; wrap is ignored.
   function automatic logic [SRAM_ADDR_W-2:0] word_index(input logic [31:0] addr,
                                                         input logic [31:0] base);
      return (SRAM_ADDR_W-1)'((addr - base) >> 2);
   endfunction

endpackage

// File: rtl/sram_controller.sv
// Serves one 32-bit MEM-stage load/store as two 16-bit async SRAM accesses.
// ready drops while an access is in flight; the pipeline freezes on it.
module sram_controller
   import sram_controller_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR     = DEFAULT_BASE_ADDR,
   parameter int          ACCESS_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic                   rd_en,
   input  logic [31:0]            address,
   input  logic [31:0]            write_data,
   output logic [31:0]            read_data,
   output logic                   ready,
   output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
   inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
   output logic                   SRAM_WE_N
);

   localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   is_wr_q, is_wr_d;
   logic [SRAM_ADDR_W-2:0] word_q, word_d;
   logic [31:0]            wdata_q, wdata_d;
   logic [31:0]            read_data_q, read_data_d;

   logic in_access;
   logic drive_dq;
   logic cnt_last;

   assign in_access = (state_q == ST_LOW) || (state_q == ST_HIGH);
   assign drive_dq  = in_access && is_wr_q;
   assign cnt_last  = (cnt_q == CNT_LAST);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      is_wr_d     = is_wr_q;
      word_d      = word_q;
      wdata_d     = wdata_q;
      read_data_d = read_data_q;
      case (state_q)
         ST_IDLE: begin
            if (rd_en || wr_en) begin
               // A simultaneous read+write is illegal and resolves to a write.
               state_d = ST_LOW;
               cnt_d   = '0;
               is_wr_d = wr_en;
               word_d  = word_index(address, BASE_ADDR);
               wdata_d = write_data;
            end
         end
         ST_LOW: begin
            if (cnt_last) begin
               state_d = ST_HIGH;
               cnt_d   = '0;
               if (!is_wr_q) read_data_d[15:0] = SRAM_DQ;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_HIGH: begin
            if (cnt_last) begin
               state_d = ST_DONE;
               cnt_d   = '0;
               if (!is_wr_q) read_data_d[31:16] = SRAM_DQ;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         is_wr_q     <= 1'b0;
         word_q      <= '0;
         wdata_q     <= '0;
         read_data_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         is_wr_q     <= is_wr_d;
         word_q      <= word_d;
         wdata_q     <= wdata_d;
         read_data_q <= read_data_d;
      end
   end

   assign read_data = read_data_q;
   assign ready     = ((state_q == ST_IDLE) && !rd_en && !wr_en) || (state_q == ST_DONE);
   assign SRAM_ADDR = in_access ? {word_q, (state_q == ST_HIGH)} : '0;
   assign SRAM_WE_N = !drive_dq;
   assign SRAM_DQ   = drive_dq ? ((state_q == ST_HIGH) ? wdata_q[31:16] : wdata_q[15:0])
                               : {SRAM_DATA_W{1'bz}};

endmodule
